// File: rtl/l1a_pkg.sv
// Shared types and command codes for the serial L1A trigger-command decoder.
package l1a_pkg;

  typedef enum logic [1:0] {UNLOCK, IDLE, SHIFT, PARITY} state_t;

  localparam logic [7:0] CMD_L1A    = 8'd0;
  localparam logic [7:0] CMD_DELTA  = 8'd1;
  localparam logic [7:0] CMD_ALIGN  = 8'd2;
  localparam logic [7:0] CMD_L1A_PS = 8'd4;
  localparam logic [7:0] CMD_PL1A   = 8'd6;
  localparam logic [7:0] CMD_RST    = 8'd7;

  typedef struct packed {
    logic l1a;
    logic ps;
    logic pl1a;
    logic align;
    logic delta;
    logic rst_cmd;
  } strobe_t;

  // Codes are zero-extended to 8 bits so one comparison serves every CODE_W.
  function automatic logic is_l1a(input logic [7:0] code);
    return (code == CMD_L1A) || (code == CMD_L1A_PS);
  endfunction

endpackage

// File: rtl/l1a_cmd_map.sv
// Registered mapping of a decoded command code onto one-cycle strobes.
module l1a_cmd_map
  import l1a_pkg::*;
#(
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_en,
  input  logic [CODE_W-1:0] code,
  output strobe_t           strobes,
  output logic              cmd_unknown
);

  logic [7:0] code_ext;
  strobe_t    map_nxt;
  logic       unk_nxt;

  assign code_ext = 8'(code);

  always_comb begin
    map_nxt = '0;
    unk_nxt = 1'b0;
    case (code_ext)
      CMD_L1A:    map_nxt.l1a = 1'b1;
      CMD_DELTA:  map_nxt.delta = 1'b1;
      CMD_ALIGN:  map_nxt.align = 1'b1;
      CMD_L1A_PS: begin
        map_nxt.l1a = 1'b1;
        map_nxt.ps  = 1'b1;
      end
      CMD_PL1A:   map_nxt.pl1a = 1'b1;
      CMD_RST:    map_nxt.rst_cmd = 1'b1;
      default:    unk_nxt = 1'b1;
    endcase
  end

  // Strobe register stage: high only on the cycle after a decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobes     <= '0;
      cmd_unknown <= 1'b0;
    end else begin
      strobes     <= dec_en ? map_nxt : '0;
      cmd_unknown <= dec_en & unk_nxt;
    end
  end

endmodule

// File: rtl/l1a_cmd_decoder.sv
// Serial trigger-command decoder: frame lock, deserialiser, strobes, L1A counter.
// Optional even-parity bit per frame is enabled by defining L1A_PARITY_EN.
module l1a_cmd_decoder
  import l1a_pkg::*;
#(
  parameter int CODE_W   = 3,
  parameter int IDLE_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              locked,
  output logic              L1A,
  output logic              PS,
  output logic              PL1A,
  output logic              ALIGN,
  output logic              DELTA,
  output logic              RST_CMD,
  output logic              cmd_valid,
  output logic [CODE_W-1:0] cmd_code,
  output logic              cmd_unknown,
  output logic              err_parity,
  output logic [CNT_W-1:0]  l1a_cnt
);

  localparam logic [3:0]       ZLAST   = 4'(IDLE_LEN - 1);
  localparam logic [3:0]       BLAST   = 4'(CODE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic [3:0]        zcnt;
  logic [3:0]        bcnt;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] shift_nxt;
  logic [CODE_W-1:0] dec_code;
  logic              dec_en;
  strobe_t           strobes;
`ifdef L1A_PARITY_EN
  logic              par_fail;
`endif

  assign shift_nxt = {shreg[CODE_W-2:0], in};
  assign locked    = (state != UNLOCK);

  // State, deserialiser and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOCK;
      zcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      l1a_cnt   <= '0;
    end else begin
      state <= state_nxt;
      zcnt  <= (state == UNLOCK && state_nxt == UNLOCK && !in) ? zcnt + 4'd1 : 4'd0;
      bcnt  <= (state == SHIFT) ? bcnt + 4'd1 : 4'd0;
      if (state == SHIFT) shreg <= shift_nxt;
      cmd_valid <= dec_en;
      if (dec_en) cmd_code <= dec_code;
      // RST_CMD is already a registered strobe, so the clear lands one edge later.
      if (strobes.rst_cmd) l1a_cnt <= '0;
      else if (dec_en && is_l1a(8'(dec_code))) l1a_cnt <= l1a_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCK: if (!in && zcnt == ZLAST) state_nxt = IDLE;
      IDLE:   if (in) state_nxt = SHIFT;
      SHIFT: begin
        if (bcnt == BLAST) begin
`ifdef L1A_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef L1A_PARITY_EN
      PARITY: state_nxt = par_fail ? UNLOCK : IDLE;
`endif
      default: state_nxt = UNLOCK;
    endcase
  end

  // Decode fires on the cycle the final frame bit is on the line.
  always_comb begin
    dec_en   = 1'b0;
    dec_code = shift_nxt;
`ifdef L1A_PARITY_EN
    par_fail = 1'b0;
    if (state == PARITY) begin
      dec_code = shreg;
      if (in == ^shreg) dec_en = 1'b1;
      else par_fail = 1'b1;
    end
`else
    if (state == SHIFT && bcnt == BLAST) dec_en = 1'b1;
`endif
  end

`ifdef L1A_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) err_parity <= 1'b0;
    else err_parity <= par_fail;
  end
`else
  assign err_parity = 1'b0;
`endif

  l1a_cmd_map #(.CODE_W(CODE_W)) u_map (
    .clk         (clk),
    .rst         (rst),
    .dec_en      (dec_en),
    .code        (dec_code),
    .strobes     (strobes),
    .cmd_unknown (cmd_unknown)
  );

  assign L1A     = strobes.l1a;
  assign PS      = strobes.ps;
  assign PL1A    = strobes.pl1a;
  assign ALIGN   = strobes.align;
  assign DELTA   = strobes.delta;
  assign RST_CMD = strobes.rst_cmd;

endmodule

// File: tb/tb_l1a_cmd_decoder.sv
// Directed bench for l1a_cmd_decoder: a CODE_W=3/CNT_W=8 instance and a CODE_W=4 instance.
module tb_l1a_cmd_decoder;

  logic clk = 1'b0;
  logic rst, in3, in4;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       locked3, l1a3, ps3, pl1a3, align3, delta3, rstc3, valid3, unk3, perr3;
  logic [2:0] code3;
  logic [7:0] cnt3;
  logic       locked4, l1a4, ps4, pl1a4, align4, delta4, rstc4, valid4, unk4, perr4;
  logic [3:0] code4;
  logic [15:0] cnt4;

  logic [5:0] strb3, strb4;
  assign strb3 = {l1a3, ps3, pl1a3, align3, delta3, rstc3};
  assign strb4 = {l1a4, ps4, pl1a4, align4, delta4, rstc4};

  l1a_cmd_decoder #(.CODE_W(3), .IDLE_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in3), .locked(locked3), .L1A(l1a3), .PS(ps3),
    .PL1A(pl1a3), .ALIGN(align3), .DELTA(delta3), .RST_CMD(rstc3),
    .cmd_valid(valid3), .cmd_code(code3), .cmd_unknown(unk3),
    .err_parity(perr3), .l1a_cnt(cnt3)
  );

  l1a_cmd_decoder #(.CODE_W(4), .IDLE_LEN(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .locked(locked4), .L1A(l1a4), .PS(ps4),
    .PL1A(pl1a4), .ALIGN(align4), .DELTA(delta4), .RST_CMD(rstc4),
    .cmd_valid(valid4), .cmd_code(code4), .cmd_unknown(unk4),
    .err_parity(perr4), .l1a_cnt(cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, code MSB first, then parity (inverted when bad) if compiled in.
  task automatic send3(input logic [2:0] c, input logic bad);
    in3 = 1'b1; tick();
    for (int i = 2; i >= 0; i--) begin in3 = c[i]; tick(); end
`ifdef L1A_PARITY_EN
    in3 = (^c) ^ bad; tick();
`else
    if (bad) in3 = 1'b0;
`endif
  endtask

  task automatic send4(input logic [3:0] c);
    in4 = 1'b1; tick();
    for (int i = 3; i >= 0; i--) begin in4 = c[i]; tick(); end
`ifdef L1A_PARITY_EN
    in4 = ^c; tick();
`endif
  endtask

  initial begin
    rst = 1'b1; in3 = 1'b0; in4 = 1'b0;
    tick(); tick();
    chk("rst_locked", 32'(locked3), 32'd0);
    chk("rst_strb", 32'(strb3), 32'd0);
    chk("rst_valid", 32'(valid3), 32'd0);
    chk("rst_cnt", 32'(cnt3), 32'd0);
    chk("rst_code", 32'(code3), 32'd0);
    rst = 1'b0;

    // Lock acquisition with an interrupted zero run.
    for (int i = 0; i < 3; i++) tick();
    chk("lock_3zeros", 32'(locked3), 32'd0);
    in3 = 1'b1; tick();
    in3 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("lock_restart", 32'(locked3), 32'd0);
    tick();
    chk("lock_4zeros", 32'(locked3), 32'd1);
    chk("lock4_dut4", 32'(locked4), 32'd1);

    // Code 0 with latency check.
    in3 = 1'b1; tick();
    in3 = 1'b0; tick(); tick();
    chk("l1a_early", 32'(l1a3), 32'd0);
    tick();
`ifdef L1A_PARITY_EN
    tick();
`endif
    chk("code0_strb", 32'(strb3), 32'b100000);
    chk("code0_valid", 32'(valid3), 32'd1);
    chk("code0_code", 32'(code3), 32'd0);
    chk("code0_cnt", 32'(cnt3), 32'd1);
    tick();
    chk("code0_oneshot", 32'(strb3), 32'd0);
    chk("code0_valid_off", 32'(valid3), 32'd0);

    send3(3'd4, 1'b0);
    chk("code4_strb", 32'(strb3), 32'b110000);
    chk("code4_cnt", 32'(cnt3), 32'd2);

    // Back-to-back frames, no gap.
    send3(3'd1, 1'b0);
    chk("b2b_delta", 32'(strb3), 32'b000010);
    chk("b2b_valid1", 32'(valid3), 32'd1);
    send3(3'd2, 1'b0);
    chk("b2b_align", 32'(strb3), 32'b000100);
    chk("b2b_code2", 32'(code3), 32'd2);
    send3(3'd6, 1'b0);
    chk("b2b_pl1a", 32'(strb3), 32'b001000);
    chk("b2b_cnt", 32'(cnt3), 32'd2);
    send3(3'd3, 1'b0);
    chk("unk3_strb", 32'(strb3), 32'd0);
    chk("unk3_flag", 32'(unk3), 32'd1);
    chk("unk3_valid", 32'(valid3), 32'd1);
    send3(3'd5, 1'b0);
    chk("unk5_flag", 32'(unk3), 32'd1);
    chk("unk5_code", 32'(code3), 32'd5);
    in3 = 1'b0; tick();
    chk("unk_oneshot", 32'(unk3), 32'd0);

    // Counter wrap at 2^CNT_W-1.
    for (int i = 0; i < 253; i++) send3(3'd0, 1'b0);
    chk("cnt_max", 32'(cnt3), 32'hFF);
    send3(3'd0, 1'b0);
    chk("cnt_wrap", 32'(cnt3), 32'h00);
    send3(3'd4, 1'b0);
    chk("cnt_after_wrap", 32'(cnt3), 32'h01);
    send3(3'd7, 1'b0);
    chk("rst_cmd_strb", 32'(strb3), 32'b000001);
    chk("rst_cmd_cnt_hold", 32'(cnt3), 32'h01);
    in3 = 1'b0; tick();
    chk("rst_cmd_cnt_clr", 32'(cnt3), 32'h00);
    chk("rst_cmd_oneshot", 32'(rstc3), 32'd0);
    chk("perr_idle", 32'(perr3), 32'd0);

    // CODE_W=4 instance: unmapped and mapped codes.
    send4(4'b1001);
    chk("w4_unk", 32'(unk4), 32'd1);
    chk("w4_unk_valid", 32'(valid4), 32'd1);
    chk("w4_unk_strb", 32'(strb4), 32'd0);
    chk("w4_unk_code", 32'(code4), 32'd9);
    send4(4'b0100);
    chk("w4_l1a_ps", 32'(strb4), 32'b110000);
    chk("w4_cnt", 32'(cnt4), 32'd1);
    send4(4'b1000);
    chk("w4_code8_unk", 32'(unk4), 32'd1);
    chk("w4_code8_strb", 32'(strb4), 32'd0);
    in4 = 1'b0; tick();

`ifdef L1A_PARITY_EN
    send3(3'b011, 1'b1);
    chk("par_err", 32'(perr3), 32'd1);
    chk("par_unlock", 32'(locked3), 32'd0);
    chk("par_novalid", 32'(valid3), 32'd0);
    send3(3'd4, 1'b0);
    chk("par_ignored", 32'(valid3), 32'd0);
    chk("par_still_unlocked", 32'(locked3), 32'd0);
    in3 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("par_relock", 32'(locked3), 32'd1);
    send3(3'd2, 1'b0);
    chk("par_ok_strb", 32'(strb3), 32'b000100);
    chk("par_ok_perr", 32'(perr3), 32'd0);
`endif

    // Reset in the middle of a frame.
    send3(3'd4, 1'b0);
    chk("pre_rst_cnt", 32'(cnt3), 32'd1);
    in3 = 1'b1; tick();
    in3 = 1'b1; tick();
    rst = 1'b1; in3 = 1'b0; tick();
    rst = 1'b0;
    chk("midrst_locked", 32'(locked3), 32'd0);
    chk("midrst_strb", 32'(strb3), 32'd0);
    chk("midrst_valid", 32'(valid3), 32'd0);
    chk("midrst_code", 32'(code3), 32'd0);
    chk("midrst_cnt", 32'(cnt3), 32'd0);
    chk("midrst_perr", 32'(perr3), 32'd0);
    tick(); tick();
    chk("midrst_nostrobe", 32'(strb3), 32'd0);
    chk("midrst_novalid", 32'(valid3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
